sram_march_bist: RTL and testbench
==================================

Name: sram_march_bist

Overview:
- Parametrised March C- built-in self-test engine for the OpenRAM testchip SRAM bank.
- Drives one shared SRAM port (addr/din/web/wmask) and one-hot-low csb across NUM_CH macros.
- Captures the selected channel's dout one cycle after each read, compares it against the expected value, and reports error count and first failing address.
- Sits between the testchip control logic and the SRAM macros, in the sram_clk domain; it replaces manual LA/GPIO-driven pattern loading for bulk testing.

Parameters:
ADDR_W, 10, SRAM address width
DATA_W, 32, data width; must be even
WMASK_W, 4, write-mask width
NUM_CH, 16, number of SRAM macros selectable
CH_W, $clog2(NUM_CH), channel-select width
ERR_CNT_W, 16, error counter width

Ports:
sram_clk  in  1  clock
resetn  in  1  synchronous active-low reset
start  in  1  begin test; sampled only in IDLE
abort  in  1  terminate a running test
ch_sel  in  CH_W  channel under test; latched on start
depth_m1  in  ADDR_W  last address tested (N = depth_m1+1); latched on start
dout_all  in  NUM_CH*DATA_W  flattened dout of all macros; channel i at [i*DATA_W +: DATA_W]
csb  out  NUM_CH  chip selects, active low
web  out  1  write enable, active low
wmask  out  WMASK_W  write mask
addr  out  ADDR_W  address
din  out  DATA_W  write data
busy  out  1  test in progress
done  out  1  test completed; held until next start
pass  out  1  done && err_count==0
err_count  out  ERR_CNT_W  saturating mismatch count
first_err_valid  out  1  at least one mismatch seen
first_err_addr  out  ADDR_W  address of first mismatch

Behaviour:
- Reset (resetn=0 at a sram_clk edge, including mid-test):
  - State goes to IDLE; csb all ones; web=1; wmask=0; addr=0; din=0.
  - busy, done, pass, first_err_valid, err_count and first_err_addr all 0.
  - Compare pipeline is cleared.
- All SRAM-side outputs are registered.
- FSM states:
  - IDLE: start=1 latches ch_sel/depth_m1, clears err_count/first_err_*/done, and goes to RUN.
  - RUN: executes elements M0..M5.
  - DRAIN: one cycle for the final compare.
  - DONE: done=1. start=1 behaves as in IDLE.
- March elements (bg = background pattern, ~bg its inverse):
  - M0: up, w bg
  - M1: up, r bg then w ~bg
  - M2: up, r ~bg then w bg
  - M3: down, r bg then w ~bg
  - M4: down, r ~bg then w bg
  - M5: down, r bg
- Timing:
  - One SRAM operation per cycle; read-then-write elements take 2 cycles per address. RUN lasts exactly 10N cycles.
  - "up" runs 0..depth_m1; "down" runs depth_m1..0. Address counter reloads at element boundary with no idle cycle.
  - busy rises the cycle after start is sampled. done rises 10N+1 cycles after busy rises, on the same edge busy falls.
- SRAM port drive:
  - csb[ch] low only on active RUN cycles; all other csb bits stay 1 throughout.
  - Write cycles: web=0, wmask all ones.
  - Read cycles: web=1, wmask=0.
- Compare path:
  - Expected data and address are pipelined with the read so that dout_all[ch] is compared on the edge one cycle after the SRAM samples the read.
  - On mismatch: err_count increments, saturating at 2^ERR_CNT_W-1.
  - On the first mismatch only: first_err_addr is captured and first_err_valid is set.
- Boundary conditions:
  - depth_m1=0 is legal: single address, RUN=10 cycles.
  - start while busy is ignored.
  - A compare pending when RUN ends is completed in DRAIN.
- abort=1 in RUN or DRAIN:
  - Next cycle goes to IDLE: csb all ones, busy=0, done stays 0.
  - err_count and first_err_* retain their values.
  - Any read issued in the abort cycle is not compared.
- Abort and start are both ignored in IDLE/DONE if not applicable; abort has priority over state progression.
- ch_sel >= NUM_CH at start: test runs, but no csb bit asserts.

Optional Feature:
MARCH_CKBD_EN:
- Defined: bg is address-dependent checkerboard, {DATA_W/2{2'b01}} when addr[0]==0 and {DATA_W/2{2'b10}} when addr[0]==1. Expected values use the same function of the pipelined address.
- Undefined: bg is all zeros (~bg is all ones).

Decomposition:
- Package sram_bist_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - march element table: direction, op count, read polarity, write polarity for M0..M5
  - op enum (READ, WRITE)
  - constants NUM_ELEM=6 and CKBD_EVEN pattern generator function
- Sub-module sram_bist_checker holds the dout mux, expected/address pipeline register, comparator, saturating err_count and first-error capture.

Test Plan:
1. Ideal memory model on ch 5, depth_m1=3, MARCH_CKBD_EN undefined -> done 41 cycles after busy rises; pass=1, err_count=0; only csb[5] ever toggles; 40 SRAM ops seen.
2. Ch 5 with bit 0 of addr 2 stuck-at-0, depth_m1=3 -> r~bg fails in M2 and M4; err_count=2, first_err_valid=1, first_err_addr=2, pass=0.
3. All bits stuck-at-1 on every address, ERR_CNT_W=2, depth_m1=7 -> err_count saturates at 3, first_err_addr=0.
4. abort at RUN cycle 15, then start with depth_m1=1 -> busy=0 and done=0 next cycle, all csb=1; the new test completes after 21 cycles with pass=1.
5. resetn low for 1 cycle mid-M3, plus start pulses while busy -> all outputs return to reset values next cycle; start during busy does not restart or extend the test.
6. MARCH_CKBD_EN defined, depth_m1=1 -> M0 writes 0x55555555 to addr 0 and 0xAAAAAAAA to addr 1; ideal memory gives pass=1.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared types for the March C- SRAM BIST: FSM states, op kinds, the march
// element table and the checkerboard background bit generator.
package sram_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef enum logic {READ, WRITE} op_t;

  typedef struct packed {
    logic       down;
    logic [1:0] op_cnt;
    op_t        first_op;
    logic       rd_inv;
    logic       wr_inv;
  } elem_t;

  localparam int NUM_ELEM = 6;

  localparam elem_t M0_E = '{down: 1'b0, op_cnt: 2'd1, first_op: WRITE, rd_inv: 1'b0, wr_inv: 1'b0};
  localparam elem_t M1_E = '{down: 1'b0, op_cnt: 2'd2, first_op: READ,  rd_inv: 1'b0, wr_inv: 1'b1};
  localparam elem_t M2_E = '{down: 1'b0, op_cnt: 2'd2, first_op: READ,  rd_inv: 1'b1, wr_inv: 1'b0};
  localparam elem_t M3_E = '{down: 1'b1, op_cnt: 2'd2, first_op: READ,  rd_inv: 1'b0, wr_inv: 1'b1};
  localparam elem_t M4_E = '{down: 1'b1, op_cnt: 2'd2, first_op: READ,  rd_inv: 1'b1, wr_inv: 1'b0};
  localparam elem_t M5_E = '{down: 1'b1, op_cnt: 2'd1, first_op: READ,  rd_inv: 1'b0, wr_inv: 1'b0};

  localparam elem_t [NUM_ELEM-1:0] MARCH_TABLE = {M5_E, M4_E, M3_E, M2_E, M1_E, M0_E};

  // Even addresses get ...0101, odd addresses the inverted pair ...1010.
  localparam logic [1:0] CKBD_EVEN = 2'b01;

  function automatic logic ckbd_bit(input logic addr_lsb, input logic bit_lsb);
    logic [1:0] pair;
    pair = addr_lsb ? ~CKBD_EVEN : CKBD_EVEN;
    return pair[bit_lsb];
  endfunction

endpackage

// File: rtl/sram_bist_checker.sv
// Read-data checker: selects the channel under test, compares it against the
// pipelined expectation and keeps a saturating error count plus first-failure address.
module sram_bist_checker
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 16,
  parameter int CH_W      = $clog2(NUM_CH),
  parameter int ERR_CNT_W = 16
) (
  input  logic                     sram_clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     capture,
  input  logic [ADDR_W-1:0]        cap_addr,
  input  logic                     cap_inv,
  input  logic [CH_W-1:0]          ch,
  input  logic [NUM_CH*DATA_W-1:0] dout_all,
  output logic [ERR_CNT_W-1:0]     err_count,
  output logic                     first_err_valid,
  output logic [ADDR_W-1:0]        first_err_addr
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic              pipe_valid;
  logic              pipe_inv;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] sel_dout;
  logic [DATA_W-1:0] bg;
  logic [DATA_W-1:0] expected;
  logic              mismatch;

  // An out-of-range channel selects nothing and reads as zero.
  always_comb begin
    sel_dout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == i[CH_W-1:0]) sel_dout = dout_all[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    bg = '0;
`ifdef MARCH_CKBD_EN
    for (int i = 0; i < DATA_W; i++) bg[i] = ckbd_bit(pipe_addr[0], i[0]);
`endif
  end

  assign expected = bg ^ {DATA_W{pipe_inv}};
  assign mismatch = pipe_valid && (sel_dout != expected);

  always_ff @(posedge sram_clk) begin
    if (!resetn) begin
      pipe_valid      <= 1'b0;
      pipe_inv        <= 1'b0;
      pipe_addr       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else begin
      pipe_valid <= capture;
      pipe_inv   <= cap_inv;
      pipe_addr  <= cap_addr;
      if (clear) begin
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_addr  <= '0;
      end else if (mismatch) begin
        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_addr  <= pipe_addr;
        end
      end
    end
  end

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST engine driving one shared OpenRAM port across NUM_CH macros.
// Define MARCH_CKBD_EN for an address-dependent checkerboard background.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int WMASK_W   = 4,
  parameter int NUM_CH    = 16,
  parameter int CH_W      = $clog2(NUM_CH),
  parameter int ERR_CNT_W = 16
) (
  input  logic                     sram_clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic [ADDR_W-1:0]        depth_m1,
  input  logic [NUM_CH*DATA_W-1:0] dout_all,
  output logic [NUM_CH-1:0]        csb,
  output logic                     web,
  output logic [WMASK_W-1:0]       wmask,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        din,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_W-1:0]     err_count,
  output logic                     first_err_valid,
  output logic [ADDR_W-1:0]        first_err_addr
);

  localparam logic [2:0]        LAST_ELEM = 3'(NUM_ELEM - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;

  state_t            state, state_n;
  logic [2:0]        elem_q, elem_n;
  logic              phase_q, phase_n;
  logic [ADDR_W-1:0] addr_n, addr_bus;
  logic [ADDR_W-1:0] depth_q;
  logic [CH_W-1:0]   ch_q, ch_use;
  logic              rd_inv_q, rd_inv_n;
  logic              start_ok;
  logic              bus_on;
  logic              is_write;
  logic              pol;
  logic [DATA_W-1:0] bg_n;
  logic [NUM_CH-1:0] csb_n;
  logic              web_n;
  logic [WMASK_W-1:0] wmask_n;
  logic [DATA_W-1:0] din_n;
  logic              capture;

  // The counters always describe the op on the bus, so the next-state logic
  // computes the following op and the bus registers load it directly.
  always_comb begin
    state_n  = state;
    elem_n   = elem_q;
    phase_n  = phase_q;
    addr_n   = addr;
    start_ok = 1'b0;
    bus_on   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_n  = RUN;
          elem_n   = '0;
          phase_n  = 1'b0;
          addr_n   = '0;
          bus_on   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (MARCH_TABLE[elem_q].op_cnt == 2'd2 && !phase_q) begin
          phase_n = 1'b1;
          bus_on  = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (MARCH_TABLE[elem_q].down ? (addr != '0) : (addr != depth_q)) begin
            addr_n = MARCH_TABLE[elem_q].down ? addr - ADDR_ONE : addr + ADDR_ONE;
            bus_on = 1'b1;
          end else if (elem_q == LAST_ELEM) begin
            state_n = DRAIN;
          end else begin
            elem_n = elem_q + 3'd1;
            addr_n = MARCH_TABLE[elem_q + 3'd1].down ? depth_q : '0;
            bus_on = 1'b1;
          end
        end
      end
      DRAIN:   state_n = abort ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    is_write = phase_n || (MARCH_TABLE[elem_n].first_op == WRITE);
    pol      = is_write ? MARCH_TABLE[elem_n].wr_inv : MARCH_TABLE[elem_n].rd_inv;
    rd_inv_n = MARCH_TABLE[elem_n].rd_inv;
    ch_use   = start_ok ? ch_sel : ch_q;

    bg_n = '0;
`ifdef MARCH_CKBD_EN
    for (int i = 0; i < DATA_W; i++) bg_n[i] = ckbd_bit(addr_n[0], i[0]);
`endif

    csb_n = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus_on && ch_use == i[CH_W-1:0]) csb_n[i] = 1'b0;
    end
    web_n    = !(bus_on && is_write);
    wmask_n  = (bus_on && is_write) ? '1 : '0;
    din_n    = (bus_on && is_write) ? (bg_n ^ {DATA_W{pol}}) : '0;
    addr_bus = bus_on ? addr_n : '0;
  end

  always_ff @(posedge sram_clk) begin
    if (!resetn) begin
      state    <= IDLE;
      elem_q   <= '0;
      phase_q  <= 1'b0;
      rd_inv_q <= 1'b0;
      depth_q  <= '0;
      ch_q     <= '0;
      csb      <= '1;
      web      <= 1'b1;
      wmask    <= '0;
      addr     <= '0;
      din      <= '0;
    end else begin
      state    <= state_n;
      elem_q   <= elem_n;
      phase_q  <= phase_n;
      rd_inv_q <= rd_inv_n;
      csb      <= csb_n;
      web      <= web_n;
      wmask    <= wmask_n;
      addr     <= addr_bus;
      din      <= din_n;
      if (start_ok) begin
        depth_q <= depth_m1;
        ch_q    <= ch_sel;
      end
    end
  end

  // A read issued in the cycle abort is sampled is dropped before the compare.
  assign capture = (state == RUN) && web && !abort;

  sram_bist_checker #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_CH   (NUM_CH),
    .CH_W     (CH_W),
    .ERR_CNT_W(ERR_CNT_W)
  ) u_checker (
    .sram_clk       (sram_clk),
    .resetn         (resetn),
    .clear          (start_ok),
    .capture        (capture),
    .cap_addr       (addr),
    .cap_inv        (rd_inv_q),
    .ch             (ch_q),
    .dout_all       (dout_all),
    .err_count      (err_count),
    .first_err_valid(first_err_valid),
    .first_err_addr (first_err_addr)
  );

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist with a behavioural SRAM bank and read-side fault injection.
module tb_sram_march_bist;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int WMASK_W   = 4;
  localparam int NUM_CH    = 16;
  localparam int CH_W      = 4;
  localparam int ERR_CNT_W = 2;
  localparam int TEST_CH   = 5;

  logic                     sram_clk = 1'b0;
  logic                     resetn;
  logic                     start;
  logic                     abort;
  logic [CH_W-1:0]          ch_sel;
  logic [ADDR_W-1:0]        depth_m1;
  logic [NUM_CH*DATA_W-1:0] dout_all;
  logic [NUM_CH-1:0]        csb;
  logic                     web;
  logic [WMASK_W-1:0]       wmask;
  logic [ADDR_W-1:0]        addr;
  logic [DATA_W-1:0]        din;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [ERR_CNT_W-1:0]     err_count;
  logic                     first_err_valid;
  logic [ADDR_W-1:0]        first_err_addr;

  int assert_count = 0;
  int fail_count   = 0;

  sram_march_bist #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .WMASK_W  (WMASK_W),
    .NUM_CH   (NUM_CH),
    .CH_W     (CH_W),
    .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .sram_clk       (sram_clk),
    .resetn         (resetn),
    .start          (start),
    .abort          (abort),
    .ch_sel         (ch_sel),
    .depth_m1       (depth_m1),
    .dout_all       (dout_all),
    .csb            (csb),
    .web            (web),
    .wmask          (wmask),
    .addr           (addr),
    .din            (din),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_valid(first_err_valid),
    .first_err_addr (first_err_addr)
  );

  always #5 sram_clk = ~sram_clk;

  // Behavioural SRAM bank: registered read port, byte-masked writes, faults on the read view.
  logic [DATA_W-1:0] mem    [NUM_CH][8];
  logic [DATA_W-1:0] dout_q [NUM_CH];
  int                fault_mode = 0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dout
    assign dout_all[g*DATA_W +: DATA_W] = dout_q[g];
  end

  function automatic logic [DATA_W-1:0] readView(input logic [DATA_W-1:0] v, input logic [2:0] a);
    if (fault_mode == 1 && a == 3'd2) return v & ~32'h1;
    if (fault_mode == 2) return '1;
    return v;
  endfunction

  always @(posedge sram_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!csb[c]) begin
        if (!web) begin
          for (int b = 0; b < WMASK_W; b++)
            if (wmask[b]) mem[c][addr[2:0]][b*8 +: 8] <= din[b*8 +: 8];
        end else begin
          dout_q[c] <= readView(mem[c][addr[2:0]], addr[2:0]);
        end
      end
    end
  end

  // Bus monitor: op count, stray chip selects, mask sanity, first two write words.
  logic              mon_clear = 1'b0;
  int                op_count;
  logic              stray_csb;
  logic              bad_mask;
  int                wr_seen;
  logic [DATA_W-1:0] first_wr [2];

  always @(posedge sram_clk) begin
    if (mon_clear) begin
      op_count  <= 0;
      stray_csb <= 1'b0;
      bad_mask  <= 1'b0;
      wr_seen   <= 0;
    end else if (csb != '1) begin
      op_count <= op_count + 1;
      if (((~csb) & ~(16'h1 << TEST_CH)) != '0) stray_csb <= 1'b1;
      if (!web ? (wmask != 4'hF) : (wmask != 4'h0)) bad_mask <= 1'b1;
      if (!web && wr_seen < 2) begin
        first_wr[wr_seen] <= din;
        wr_seen <= wr_seen + 1;
      end
    end
  end

  function automatic logic [DATA_W-1:0] bgOf(input logic a0);
`ifdef MARCH_CKBD_EN
    return a0 ? 32'hAAAA_AAAA : 32'h5555_5555;
`else
    return a0 ? 32'h0 : 32'h0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [ADDR_W-1:0] depth);
    @(negedge sram_clk);
    start     = 1'b1;
    ch_sel    = ch;
    depth_m1  = depth;
    mon_clear = 1'b1;
    @(negedge sram_clk);
    start     = 1'b0;
    mon_clear = 1'b0;
  endtask

  task automatic pulseStartWhileBusy();
    start    = 1'b1;
    ch_sel   = 4'd0;
    depth_m1 = 10'd0;
    @(negedge sram_clk);
    start    = 1'b0;
    ch_sel   = 4'(TEST_CH);
    depth_m1 = 10'd3;
  endtask

  task automatic waitDone(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      @(negedge sram_clk);
      cyc++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_csb"},   64'(csb), 64'hFFFF);
    checkOutput({tag, "_web"},   64'(web), 64'd1);
    checkOutput({tag, "_wmask"}, 64'(wmask), 64'd0);
    checkOutput({tag, "_addr"},  64'(addr), 64'd0);
    checkOutput({tag, "_din"},   64'(din), 64'd0);
    checkOutput({tag, "_busy"},  64'(busy), 64'd0);
    checkOutput({tag, "_done"},  64'(done), 64'd0);
    checkOutput({tag, "_pass"},  64'(pass), 64'd0);
    checkOutput({tag, "_err"},   64'(err_count), 64'd0);
    checkOutput({tag, "_fev"},   64'(first_err_valid), 64'd0);
    checkOutput({tag, "_fea"},   64'(first_err_addr), 64'd0);
  endtask

  initial begin
    int cyc;
    resetn   = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    ch_sel   = 4'(TEST_CH);
    depth_m1 = 10'd3;
    repeat (2) @(negedge sram_clk);
    checkResetValues("por");
    resetn = 1'b1;

    $display("[TB] ideal memory, ch 5, depth_m1=3");
    applyStimulus(4'(TEST_CH), 10'd3);
    checkOutput("t1_busy_rise", 64'(busy), 64'd1);
    waitDone(100, cyc);
    checkOutput("t1_done_cycles", 64'(cyc), 64'd41);
    checkOutput("t1_busy_fall", 64'(busy), 64'd0);
    checkOutput("t1_pass", 64'(pass), 64'd1);
    checkOutput("t1_err", 64'(err_count), 64'd0);
    checkOutput("t1_ops", 64'(op_count), 64'd40);
    checkOutput("t1_stray_csb", 64'(stray_csb), 64'd0);
    checkOutput("t1_mask", 64'(bad_mask), 64'd0);
    checkOutput("t1_wr0", 64'(first_wr[0]), 64'(bgOf(1'b0)));
    checkOutput("t1_wr1", 64'(first_wr[1]), 64'(bgOf(1'b1)));
    checkOutput("t1_mem0", 64'(mem[TEST_CH][0]), 64'(bgOf(1'b0)));
    checkOutput("t1_mem1", 64'(mem[TEST_CH][1]), 64'(bgOf(1'b1)));

    $display("[TB] addr 2 bit 0 stuck-at-0");
    fault_mode = 1;
    applyStimulus(4'(TEST_CH), 10'd3);
    checkOutput("t2_done_clear", 64'(done), 64'd0);
    waitDone(100, cyc);
    checkOutput("t2_done_cycles", 64'(cyc), 64'd41);
`ifdef MARCH_CKBD_EN
    checkOutput("t2_err", 64'(err_count), 64'd3);
`else
    checkOutput("t2_err", 64'(err_count), 64'd2);
`endif
    checkOutput("t2_fev", 64'(first_err_valid), 64'd1);
    checkOutput("t2_fea", 64'(first_err_addr), 64'd2);
    checkOutput("t2_pass", 64'(pass), 64'd0);

    $display("[TB] all bits stuck-at-1, depth_m1=7");
    fault_mode = 2;
    applyStimulus(4'(TEST_CH), 10'd7);
    waitDone(200, cyc);
    checkOutput("t3_done_cycles", 64'(cyc), 64'd81);
    checkOutput("t3_err_sat", 64'(err_count), 64'd3);
    checkOutput("t3_fea", 64'(first_err_addr), 64'd0);
    checkOutput("t3_fev", 64'(first_err_valid), 64'd1);

    $display("[TB] abort on a read cycle keeps earlier errors");
    applyStimulus(4'(TEST_CH), 10'd3);
    repeat (6) @(negedge sram_clk);
    abort = 1'b1;
    @(negedge sram_clk);
    abort = 1'b0;
    checkOutput("t4a_busy", 64'(busy), 64'd0);
    checkOutput("t4a_done", 64'(done), 64'd0);
    checkOutput("t4a_csb", 64'(csb), 64'hFFFF);
    repeat (3) @(negedge sram_clk);
    checkOutput("t4a_err", 64'(err_count), 64'd1);
    checkOutput("t4a_fev", 64'(first_err_valid), 64'd1);
    checkOutput("t4a_fea", 64'(first_err_addr), 64'd0);

    $display("[TB] abort at RUN cycle 15 then restart with depth_m1=1");
    fault_mode = 0;
    applyStimulus(4'(TEST_CH), 10'd3);
    repeat (15) @(negedge sram_clk);
    abort = 1'b1;
    @(negedge sram_clk);
    abort = 1'b0;
    checkOutput("t4_busy", 64'(busy), 64'd0);
    checkOutput("t4_done", 64'(done), 64'd0);
    checkOutput("t4_csb", 64'(csb), 64'hFFFF);
    applyStimulus(4'(TEST_CH), 10'd1);
    waitDone(100, cyc);
    checkOutput("t4_done_cycles", 64'(cyc), 64'd21);
    checkOutput("t4_pass", 64'(pass), 64'd1);
    checkOutput("t4_ops", 64'(op_count), 64'd20);

    $display("[TB] reset mid-M3, then start pulses while busy");
    fault_mode = 1;
    applyStimulus(4'(TEST_CH), 10'd3);
    repeat (22) @(negedge sram_clk);
    checkOutput("t5_err_before", 64'(err_count), 64'd1);
    resetn = 1'b0;
    @(negedge sram_clk);
    resetn = 1'b1;
    checkResetValues("t5_rst");
    fault_mode = 0;
    applyStimulus(4'(TEST_CH), 10'd3);
    repeat (9) @(negedge sram_clk);
    pulseStartWhileBusy();
    repeat (19) @(negedge sram_clk);
    pulseStartWhileBusy();
    waitDone(100, cyc);
    checkOutput("t5_done_cycles", 64'(cyc + 30), 64'd41);
    checkOutput("t5_stray_csb", 64'(stray_csb), 64'd0);
    checkOutput("t5_ops", 64'(op_count), 64'd40);
    checkOutput("t5_pass", 64'(pass), 64'd1);

    $display("[TB] single address, depth_m1=0");
    applyStimulus(4'(TEST_CH), 10'd0);
    waitDone(50, cyc);
    checkOutput("t6_done_cycles", 64'(cyc), 64'd11);
    checkOutput("t6_pass", 64'(pass), 64'd1);
    checkOutput("t6_ops", 64'(op_count), 64'd10);
    checkOutput("t6_mem0", 64'(mem[TEST_CH][0]), 64'(bgOf(1'b0)));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
